// File: rtl/uart_fifo_ipu.sv
// UART interface unit: TX/RX byte FIFOs, runtime bit divisor, sticky error flags and IRQ.
// Define UART_PARITY_EN to add an even parity bit to both TX and RX frames (8E1 instead of 8N1).
module uart_fifo_ipu #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int DIV_RST = 868
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_i,
    input  logic              rd_i,
    input  logic [1:0]        addr_i,
    input  logic [DATA_W-1:0] entrada_i,
    output logic [DATA_W-1:0] salida_o,
    input  logic              rx,
    output logic              tx,
    output logic              irq_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    logic w_wr_ctrl, w_wr_data, w_wr_div, w_rd_data;
    logic [7:0]  r_tx_mem [DEPTH];
    logic [7:0]  r_rx_mem [DEPTH];
    logic [AW:0] r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp, w_tx_lvl, w_rx_lvl;
    logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic w_tx_push, w_tx_pop, w_rx_push, w_rx_pop, w_rx_push_req;
    logic [7:0]  w_tx_head, w_rx_head, w_rx_byte;
    logic [15:0] r_div, w_div_wr;
    logic r_rx_ie, r_tx_ie, r_ovr, r_ferr, r_irq, w_perr, w_ovr_set, w_ferr_set;
    logic [31:0] w_status;
    logic w_unused;

    assign w_wr_ctrl = wr_i && (addr_i == 2'd0);
    assign w_wr_data = wr_i && (addr_i == 2'd1);
    assign w_wr_div  = wr_i && (addr_i == 2'd2);
    assign w_rd_data = rd_i && (addr_i == 2'd1);
    assign w_unused  = ^{entrada_i[DATA_W-1:26], entrada_i[23:16]};

    // The extra pointer MSB tells full (MSBs differ) from empty (pointers equal).
    assign w_tx_lvl   = r_tx_wp - r_tx_rp;
    assign w_rx_lvl   = r_rx_wp - r_rx_rp;
    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_tx_full  = (r_tx_wp[AW] != r_tx_rp[AW]) && (r_tx_wp[AW-1:0] == r_tx_rp[AW-1:0]);
    assign w_rx_full  = (r_rx_wp[AW] != r_rx_rp[AW]) && (r_rx_wp[AW-1:0] == r_rx_rp[AW-1:0]);
    assign w_tx_head  = r_tx_mem[r_tx_rp[AW-1:0]];
    assign w_rx_head  = r_rx_mem[r_rx_rp[AW-1:0]];

    assign w_tx_push  = w_wr_data && !w_tx_full;
    assign w_rx_pop   = w_rd_data && !w_rx_empty;
    assign w_rx_push  = w_rx_push_req && (!w_rx_full || w_rx_pop);
    assign w_ovr_set  = w_rx_push_req && w_rx_full && !w_rx_pop;

    // NOTE: storage arrays are deliberately not reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[AW-1:0]] <= entrada_i[7:0];
        if (w_rx_push) r_rx_mem[r_rx_wp[AW-1:0]] <= w_rx_byte;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else begin
            if (w_tx_push) r_tx_wp <= r_tx_wp + PTR_ONE;
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + PTR_ONE;
            if (w_rx_push) r_rx_wp <= r_rx_wp + PTR_ONE;
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + PTR_ONE;
        end
    end

    assign w_div_wr = (entrada_i[15:0] < 16'd4) ? 16'd4 : entrada_i[15:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div   <= 16'(DIV_RST);
            r_rx_ie <= 1'b0;
            r_tx_ie <= 1'b0;
            r_ovr   <= 1'b0;
            r_ferr  <= 1'b0;
            r_irq   <= 1'b0;
        end else begin
            if (w_wr_div) r_div <= w_div_wr;
            if (w_wr_ctrl) begin
                r_rx_ie <= entrada_i[24];
                r_tx_ie <= entrada_i[25];
                if (entrada_i[4]) r_ovr  <= 1'b0;
                if (entrada_i[7]) r_ferr <= 1'b0;
            end
            if (w_ovr_set)  r_ovr  <= 1'b1;
            if (w_ferr_set) r_ferr <= 1'b1;
            r_irq <= (r_rx_ie && !w_rx_empty) || (r_tx_ie && w_tx_empty);
        end
    end
    assign irq_o = r_irq;

    // ---------------- Transmitter ----------------
    state_t      r_tx_st, w_tx_st;
    logic [15:0] r_tx_cnt, w_tx_cnt_n, r_tx_div, w_tx_div_n;
    logic [2:0]  r_tx_bit, w_tx_bit_n;
    logic [7:0]  r_tx_sh, w_tx_sh_n;
    logic        r_tx_par, w_tx_par_n, r_tx, w_tx_n, w_tx_done;

    assign w_tx_done = (r_tx_cnt == r_tx_div - 16'd1);

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_tx_st    = r_tx_st;
        w_tx_cnt_n = r_tx_cnt + 16'd1;
        w_tx_div_n = r_tx_div;
        w_tx_bit_n = r_tx_bit;
        w_tx_sh_n  = r_tx_sh;
        w_tx_par_n = r_tx_par;
        w_tx_pop   = 1'b0;
        w_tx_n     = 1'b1;
        case (r_tx_st)
            S_IDLE: begin
                w_tx_cnt_n = '0;
                if (!w_tx_empty) w_tx_st = S_START;
            end
            S_START: if (w_tx_done) begin
                w_tx_cnt_n = '0;
                w_tx_bit_n = '0;
                w_tx_st    = S_DATA;
            end
            S_DATA: if (w_tx_done) begin
                w_tx_cnt_n = '0;
                w_tx_sh_n  = {1'b0, r_tx_sh[7:1]};
                w_tx_bit_n = r_tx_bit + 3'd1;
                if (r_tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                    w_tx_st = S_PARITY;
`else
                    w_tx_st = S_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: if (w_tx_done) begin
                w_tx_cnt_n = '0;
                w_tx_st    = S_STOP;
            end
`endif
            S_STOP: if (w_tx_done) begin
                w_tx_cnt_n = '0;
                w_tx_st    = w_tx_empty ? S_IDLE : S_START;
            end
            default: w_tx_st = S_IDLE;
        endcase
        // Frame start: pop the head and freeze the divisor for the whole frame.
        if ((r_tx_st == S_IDLE || (r_tx_st == S_STOP && w_tx_done)) && !w_tx_empty) begin
            w_tx_pop   = 1'b1;
            w_tx_div_n = r_div;
            w_tx_sh_n  = w_tx_head;
            w_tx_par_n = ^w_tx_head;
        end
        case (w_tx_st)
            S_START:  w_tx_n = 1'b0;
            S_DATA:   w_tx_n = w_tx_sh_n[0];
            S_PARITY: w_tx_n = r_tx_par;
            default:  w_tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_st  <= S_IDLE;
            r_tx_cnt <= '0;
            r_tx_div <= 16'(DIV_RST);
            r_tx_bit <= '0;
            r_tx_sh  <= '0;
            r_tx_par <= 1'b0;
            r_tx     <= 1'b1;
        end else begin
            r_tx_st  <= w_tx_st;
            r_tx_cnt <= w_tx_cnt_n;
            r_tx_div <= w_tx_div_n;
            r_tx_bit <= w_tx_bit_n;
            r_tx_sh  <= w_tx_sh_n;
            r_tx_par <= w_tx_par_n;
            r_tx     <= w_tx_n;
        end
    end
    assign tx = r_tx;

    // ---------------- Receiver ----------------
    state_t      r_rx_st, w_rx_st;
    logic [15:0] r_rx_cnt, w_rx_cnt_n, r_rx_div, w_rx_div_n, w_rx_half;
    logic [2:0]  r_rx_bit, w_rx_bit_n;
    logic [7:0]  r_rx_sh, w_rx_sh_n;
    logic        r_rx_s1, r_rx_s2, r_rx_d, w_rx_fall, w_rx_tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_rx_s1 <= rx;
            r_rx_s2 <= r_rx_s1;
            r_rx_d  <= r_rx_s2;
        end
    end

    assign w_rx_fall = r_rx_d && !r_rx_s2;
    assign w_rx_half = {1'b0, r_rx_div[15:1]};
    assign w_rx_tick = (r_rx_st == S_START) ? (r_rx_cnt == w_rx_half - 16'd1)
                                            : (r_rx_cnt == r_rx_div - 16'd1);
    assign w_rx_byte = r_rx_sh;

`ifdef UART_PARITY_EN
    logic r_perr, w_perr_set;
`endif

    always_comb begin
        w_rx_st       = r_rx_st;
        w_rx_cnt_n    = r_rx_cnt + 16'd1;
        w_rx_div_n    = r_rx_div;
        w_rx_bit_n    = r_rx_bit;
        w_rx_sh_n     = r_rx_sh;
        w_rx_push_req = 1'b0;
        w_ferr_set    = 1'b0;
`ifdef UART_PARITY_EN
        w_perr_set    = 1'b0;
`endif
        case (r_rx_st)
            S_IDLE: begin
                w_rx_cnt_n = '0;
                if (w_rx_fall) begin
                    w_rx_div_n = r_div;
                    w_rx_st    = S_START;
                end
            end
            S_START: if (w_rx_tick) begin
                w_rx_cnt_n = '0;
                w_rx_bit_n = '0;
                w_rx_st    = r_rx_s2 ? S_IDLE : S_DATA;
            end
            S_DATA: if (w_rx_tick) begin
                w_rx_cnt_n = '0;
                w_rx_sh_n  = {r_rx_s2, r_rx_sh[7:1]};
                w_rx_bit_n = r_rx_bit + 3'd1;
                if (r_rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                    w_rx_st = S_PARITY;
`else
                    w_rx_st = S_STOP;
`endif
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: if (w_rx_tick) begin
                w_rx_cnt_n = '0;
                w_perr_set = (r_rx_s2 != ^r_rx_sh);
                w_rx_st    = S_STOP;
            end
`endif
            S_STOP: if (w_rx_tick) begin
                w_rx_cnt_n    = '0;
                w_rx_push_req = r_rx_s2;
                w_ferr_set    = !r_rx_s2;
                w_rx_st       = S_IDLE;
            end
            default: w_rx_st = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_st  <= S_IDLE;
            r_rx_cnt <= '0;
            r_rx_div <= 16'(DIV_RST);
            r_rx_bit <= '0;
            r_rx_sh  <= '0;
        end else begin
            r_rx_st  <= w_rx_st;
            r_rx_cnt <= w_rx_cnt_n;
            r_rx_div <= w_rx_div_n;
            r_rx_bit <= w_rx_bit_n;
            r_rx_sh  <= w_rx_sh_n;
        end
    end

`ifdef UART_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perr <= 1'b0;
        end else begin
            if (w_wr_ctrl && entrada_i[5]) r_perr <= 1'b0;
            if (w_perr_set) r_perr <= 1'b1;
        end
    end
    assign w_perr = r_perr;
`else
    assign w_perr = 1'b0;
`endif

    // ---------------- Register read ----------------
    assign w_status = {6'd0, r_tx_ie, r_rx_ie, 8'(w_tx_lvl), 8'(w_rx_lvl),
                       r_ferr, (r_tx_st != S_IDLE), w_perr, r_ovr,
                       w_rx_empty, w_rx_full, w_tx_empty, w_tx_full};

    always_comb begin
        salida_o = '0;
        case (addr_i)
            2'd0:    salida_o = DATA_W'(w_status);
            2'd1:    salida_o = w_rx_empty ? '0 : DATA_W'(w_rx_head);
            2'd2:    salida_o = DATA_W'(r_div);
            default: salida_o = '0;
        endcase
    end
endmodule

// File: tb/tb_uart_fifo_ipu.sv
// Scoreboard bench for uart_fifo_ipu: register reads and decoded TX frames are checked by monitors.
// Default 8N1 build; the parity checks activate when UART_PARITY_EN is defined.
module tb_uart_fifo_ipu;
`ifdef UART_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_i = 1'b0, rd_i = 1'b0, peek = 1'b0;
    logic [1:0]  addr_i = '0;
    logic [31:0] entrada_i = '0;
    logic [31:0] salida_o;
    logic        rx_w, tx_w, irq_w;
    logic        r_loop = 1'b0, r_rx_drv = 1'b1;
    int          tb_div = 868;
    int          n_checks = 0, n_fail = 0;

    logic [7:0]  tx_q[$];
    logic [31:0] rd_exp_q[$];
    string       rd_name_q[$];

    assign rx_w = r_loop ? tx_w : r_rx_drv;

    uart_fifo_ipu #(.DATA_W(32), .DEPTH(DEPTH), .DIV_RST(868)) dut (
        .clk(clk), .rst(rst), .wr_i(wr_i), .rd_i(rd_i), .addr_i(addr_i),
        .entrada_i(entrada_i), .salida_o(salida_o), .rx(rx_w), .tx(tx_w), .irq_o(irq_w)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        addr_i = a; entrada_i = d; wr_i = 1'b1;
        cycles(1);
        wr_i = 1'b0; entrada_i = '0;
    endtask

    task automatic bus_read(input logic [1:0] a, input logic pop, input logic [31:0] exp, input string name);
        rd_exp_q.push_back(exp);
        rd_name_q.push_back(name);
        addr_i = a; rd_i = pop; peek = 1'b1;
        cycles(1);
        rd_i = 1'b0; peek = 1'b0;
    endtask

    task automatic drive_rx_byte(input logic [7:0] b, input logic stop, input logic bad_par);
        r_rx_drv = 1'b0;
        cycles(tb_div);
        for (int i = 0; i < 8; i++) begin
            r_rx_drv = b[i];
            cycles(tb_div);
        end
`ifdef UART_PARITY_EN
        r_rx_drv = (^b) ^ bad_par;
        cycles(tb_div);
`else
        if (bad_par) r_rx_drv = 1'b1;
`endif
        r_rx_drv = stop;
        cycles(tb_div);
        r_rx_drv = 1'b1;
        cycles(2 * tb_div);
    endtask

    // Read monitor: compares the addressed register against the queued expectation.
    always @(negedge clk) begin
        if (peek) begin
            if (rd_exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL rd_scoreboard: read seen with no expected value queued");
            end else begin
                check(rd_name_q.pop_front(), salida_o, rd_exp_q.pop_front());
            end
        end
    end

    // TX monitor: decodes each frame on tx at mid-bit and checks it against the expected byte queue.
    initial begin : tx_mon
        logic [7:0] b;
        int d;
        wait (rst === 1'b0);
        wait (rst === 1'b1);
        forever begin
            @(negedge clk);
            if (tx_w === 1'b0) begin
                d = tb_div;
                repeat (d / 2) @(negedge clk);
                check("tx_start_bit", 32'(tx_w), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (d) @(negedge clk);
                    b[i] = tx_w;
                end
`ifdef UART_PARITY_EN
                repeat (d) @(negedge clk);
                check("tx_parity_bit", 32'(tx_w), 32'(^b));
`endif
                repeat (d) @(negedge clk);
                check("tx_stop_bit", 32'(tx_w), 32'd1);
                if (tx_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL tx_scoreboard: unexpected frame got 0x%02h", b);
                end else begin
                    check("tx_byte", 32'(b), 32'(tx_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 rst = 1'b0;
        cycles(3);
        check("reset_tx", 32'(tx_w), 32'd1);
        check("reset_irq", 32'(irq_w), 32'd0);
        rst = 1'b1;
        cycles(1);
        bus_read(2'd0, 1'b0, 32'h0000_000A, "reset_status");
        bus_read(2'd2, 1'b0, 32'd868, "reset_divisor");
        bus_read(2'd1, 1'b0, 32'd0, "reset_data_empty");
        bus_read(2'd3, 1'b0, 32'd0, "reserved_reads_0");

        bus_write(2'd2, 32'd2);
        bus_read(2'd2, 1'b0, 32'd4, "divisor_min_clamp");
        bus_write(2'd2, 32'd4);
        tb_div = 4;

        // Back-to-back TX frames 0x55, 0xA3.
        tx_q.push_back(8'h55);
        tx_q.push_back(8'hA3);
        bus_write(2'd1, 32'h55);
        check("tx_idle_before_start", 32'(tx_w), 32'd1);
        bus_write(2'd1, 32'hA3);
        check("tx_start_latency", 32'(tx_w), 32'd0);
        bus_read(2'd0, 1'b0, 32'h0001_0048, "status_tx_busy_count1");
        cycles(FB * 4 - 2);
        check("tx_first_stop_last_cycle", 32'(tx_w), 32'd1);
        cycles(1);
        check("tx_back_to_back_start", 32'(tx_w), 32'd0);
        cycles(FB * 4 + 8);
        bus_read(2'd0, 1'b0, 32'h0000_000A, "status_after_tx");

        // Loopback 0x3C.
        r_loop = 1'b1;
        tx_q.push_back(8'h3C);
        bus_write(2'd1, 32'h3C);
        cycles(FB * 4 + 12);
        bus_read(2'd0, 1'b0, 32'h0000_0102, "loop_rx_count1");
        bus_read(2'd1, 1'b1, 32'h3C, "loop_rx_data");
        bus_read(2'd0, 1'b0, 32'h0000_000A, "loop_rx_empty_after_pop");
        r_loop = 1'b0;
        cycles(4);

        // Overrun: DEPTH+1 frames without popping.
        for (int i = 0; i <= DEPTH; i++) drive_rx_byte(8'(8'h10 + i), 1'b1, 1'b0);
        bus_read(2'd0, 1'b0, 32'h0000_0816, "overrun_full_status");
        for (int i = 0; i < DEPTH; i++) bus_read(2'd1, 1'b1, 32'(8'h10 + i), "overrun_readback");
        bus_read(2'd1, 1'b0, 32'd0, "overrun_9th_dropped");
        bus_write(2'd0, 32'h10);
        bus_read(2'd0, 1'b0, 32'h0000_000A, "overrun_cleared");

        // Framing error and glitch rejection.
        drive_rx_byte(8'h81, 1'b0, 1'b0);
        bus_read(2'd0, 1'b0, 32'h0000_008A, "frame_err_set");
        bus_write(2'd0, 32'h80);
        bus_read(2'd0, 1'b0, 32'h0000_000A, "frame_err_cleared");
        r_rx_drv = 1'b0;
        cycles(1);
        r_rx_drv = 1'b1;
        cycles(40);
        bus_read(2'd0, 1'b0, 32'h0000_000A, "glitch_rejected");

        // IRQ behaviour.
        bus_write(2'd0, 32'h0100_0000);
        cycles(2);
        check("irq_rx_en_idle", 32'(irq_w), 32'd0);
        drive_rx_byte(8'h5A, 1'b1, 1'b0);
        check("irq_rx_rise", 32'(irq_w), 32'd1);
        bus_read(2'd0, 1'b0, 32'h0100_0102, "irq_status");
        bus_read(2'd1, 1'b1, 32'h5A, "irq_rx_data");
        check("irq_still_high_at_pop", 32'(irq_w), 32'd1);
        cycles(1);
        check("irq_fall_after_pop", 32'(irq_w), 32'd0);
        bus_write(2'd0, 32'h0200_0000);
        cycles(2);
        check("irq_tx_empty", 32'(irq_w), 32'd1);
        bus_read(2'd0, 1'b0, 32'h0200_000A, "tx_irq_en_status");
        bus_write(2'd0, 32'h0);
        cycles(2);
        check("irq_disabled", 32'(irq_w), 32'd0);

`ifdef UART_PARITY_EN
        drive_rx_byte(8'h07, 1'b1, 1'b1);
        bus_read(2'd0, 1'b0, 32'h0000_0122, "parity_err_set");
        bus_read(2'd1, 1'b1, 32'h07, "parity_byte_kept");
        bus_write(2'd0, 32'h20);
        bus_read(2'd0, 1'b0, 32'h0000_000A, "parity_err_cleared");
`endif

        // Divisor change mid-frame applies from the next frame.
        tx_q.push_back(8'h0F);
        bus_write(2'd1, 32'h0F);
        cycles(5);
        bus_write(2'd2, 32'd6);
        tb_div = 6;
        tx_q.push_back(8'hF0);
        bus_write(2'd1, 32'hF0);
        cycles(FB * 4 + FB * 6 + 20);
        bus_read(2'd2, 1'b0, 32'd6, "divisor_6");
        bus_read(2'd0, 1'b0, 32'h0000_000A, "final_status");

        cycles(4);
        check("tx_frames_all_seen", 32'(tx_q.size()), 32'd0);
        check("reads_all_checked", 32'(rd_exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
